cam_pwr_seq: RTL and testbench
==============================

Name: cam_pwr_seq

Overview:
- Camera power-up/reset sequencer in the mclk domain, beside the clock/reset generator.
- Drives the sensor PWDN and RESETB pins and gates XCLK.
- Asserts cam_ready once the datasheet timing has elapsed, so that downstream SCCB init can start.
- Supports a software restart and a standby (power-down) request with timed wake-up.

Parameters:
- T_PWDN, 4096: mclk cycles with PWDN high and XCLK off after reset or restart.
- T_RST, 2048: mclk cycles with RESETB low while XCLK runs.
- T_SETTLE, 65536: mclk cycles after RESETB release (or standby exit) before ready.
- CNT_W, 24: delay counter width. Each T_* must be at least 1 and at most 2^CNT_W.

Ports:
- mclk  in  1  master clock, rising edge.
- w_Reset_MCLKsync_n  in  1  reset, asynchronous, active-low, already synchronised to mclk.
- restart  in  1  synchronous pulse; restarts the full sequence.
- standby_req  in  1  synchronous level; 1 requests sensor power-down.
- cam_pwdn  out  1  sensor PWDN pin, 1 = powered down.
- cam_resetb  out  1  sensor RESETB pin, 0 = in reset.
- cam_xclk_en  out  1  enable for the camera clock output gate.
- cam_ready  out  1  1 = sensor usable (SCCB may start).
- seq_state  out  3  current state code, for debug.

Behaviour:
- Reset value of every output and register:
  - state S_PWDN, cnt = 0.
  - cam_pwdn = 1, cam_resetb = 0, cam_xclk_en = 0, cam_ready = 0, seq_state = 0.
- States, with the outputs driven in each state (pwdn / resetb / xclk_en / ready):
  - S_PWDN (0): 1/0/0/0.
  - S_RST (1): 0/0/1/0.
  - S_SETTLE (2): 0/1/1/0.
  - S_READY (3): 0/1/1/1.
  - S_STBY (4): 1/1/1/0.
- Codes 5-7 are illegal; go to S_PWDN on the next edge.
- All outputs are flops loaded from the next-state decode, so they change on the same edge as the state register. No combinational outputs.
- Delay counting:
  - cnt clears on every state change.
  - cnt increments each cycle while in a timed state (S_PWDN, S_RST, S_SETTLE).
  - The exit edge is the one where cnt == T-1, so the state lasts exactly T cycles.
  - cnt holds at 0 in S_READY and S_STBY and never wraps.
- Transitions:
  - S_PWDN -> S_RST after T_PWDN cycles.
  - S_RST -> S_SETTLE after T_RST cycles.
  - S_SETTLE -> S_READY after T_SETTLE cycles.
  - S_READY -> S_STBY when standby_req = 1.
  - S_STBY -> S_SETTLE when standby_req = 0. Wake-up takes the full T_SETTLE before ready returns; RESETB is not pulsed.
  - In S_PWDN, S_RST and S_SETTLE, standby_req is ignored. It is sampled again on reaching S_READY; if it is still 1, the next edge goes to S_STBY.
- Priority:
  - restart = 1 in any state (including S_PWDN) forces S_PWDN with cnt = 0 on the next edge.
  - restart wins over standby_req and over a timer expiry in the same cycle.
  - A restart held high keeps the block in S_PWDN. Timing restarts after restart falls.
- Reset mid-operation: asynchronous assertion returns all outputs to their reset values immediately, independent of mclk.
- seq_state equals the state code, registered.

Test Plan:
- Use T_PWDN=4, T_RST=3, T_SETTLE=5. Edge 1 is the first mclk rising edge after w_Reset_MCLKsync_n deasserts.
- Power-up: release reset, inputs 0.
  - cam_pwdn falls and cam_xclk_en rises at edge 4.
  - cam_resetb rises at edge 7.
  - cam_ready rises at edge 12; seq_state reads 0→1→2→3 at edges 4/7/12.
- Standby: in S_READY, set standby_req=1 at edge N.
  - At edge N, ready=0 and pwdn=1.
  - Drop standby_req at edge M: pwdn=0 at edge M and ready=1 at edge M+5. resetb stays 1 throughout.
- Restart mid-sequence: pulse restart during S_RST at cnt=1.
  - Next edge: state 0, pwdn=1, resetb=0, xclk_en=0.
  - ready then rises 12 edges later.
- Simultaneous events:
  - restart with standby_req=1 in S_READY → S_PWDN, not S_STBY.
  - restart on the S_SETTLE expiry edge → S_PWDN; ready never pulses.
- Standby during sequencing: standby_req=1 from edge 2 onward → ready never asserts; S_STBY entered at edge 13.
- Async reset: assert w_Reset_MCLKsync_n=0 between edges while in S_READY.
  - Outputs go to 1/0/0/0 without a clock edge.
  - After release, the power-up timing repeats exactly.

Source files
------------

// File: rtl/cam_pwr_seq.sv
// Camera power-up / reset sequencer, mclk domain.
// Drives the sensor PWDN and RESETB pins and the XCLK gate enable.
// Raises cam_ready once the power-down, reset and settle windows have elapsed.
// Also handles a software restart and a standby request with a timed wake-up.
// Every output is a flop loaded from the next-state decode, so all pins move
// on the same mclk edge as the state register.

module cam_pwr_seq #(
  parameter int T_PWDN   = 4096,   // cycles with PWDN high and XCLK off
  parameter int T_RST    = 2048,   // cycles with RESETB low and XCLK running
  parameter int T_SETTLE = 65536,  // cycles after RESETB release / standby exit
  parameter int CNT_W    = 24      // delay counter width
) (
  input  logic       mclk,
  input  logic       w_Reset_MCLKsync_n,
  input  logic       restart,
  input  logic       standby_req,
  output logic       cam_pwdn,
  output logic       cam_resetb,
  output logic       cam_xclk_en,
  output logic       cam_ready,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_PWDN   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_READY  = 3'd3,
    S_STBY   = 3'd4
  } state_t;

  // Terminal counts: a timed state exits on the edge where cnt == T-1,
  // so it lasts exactly T cycles counting the entry edge.
  localparam logic [CNT_W-1:0] LAST_PWDN   = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0] LAST_RST    = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic             pwdn_r;
  logic             resetb_r;
  logic             xclk_en_r;
  logic             ready_r;
  logic [2:0]       seq_state_r;

  logic             pwdn_nxt_s;
  logic             resetb_nxt_s;
  logic             xclk_en_nxt_s;
  logic             ready_nxt_s;

  // Next-state and delay-counter decode; restart overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (restart) begin
      state_nxt_s = S_PWDN;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        S_PWDN: begin
          if (cnt_r == LAST_PWDN) begin
            state_nxt_s = S_RST;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = S_PWDN;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        S_RST: begin
          if (cnt_r == LAST_RST) begin
            state_nxt_s = S_SETTLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = S_RST;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        S_SETTLE: begin
          // standby_req is deliberately ignored until S_READY is reached
          if (cnt_r == LAST_SETTLE) begin
            state_nxt_s = S_READY;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = S_SETTLE;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        S_READY: begin
          cnt_nxt_s = CNT_ZERO;
          if (standby_req) begin
            state_nxt_s = S_STBY;
          end else begin
            state_nxt_s = S_READY;
          end
        end
        S_STBY: begin
          // Wake-up re-runs the settle window but leaves RESETB released
          cnt_nxt_s = CNT_ZERO;
          if (!standby_req) begin
            state_nxt_s = S_SETTLE;
          end else begin
            state_nxt_s = S_STBY;
          end
        end
        default: begin
          // Codes 5-7 are unreachable; recover through a full power cycle
          state_nxt_s = S_PWDN;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Pin decode from the next state so the pin flops track the state flop.
  always_comb begin
    pwdn_nxt_s    = 1'b1;
    resetb_nxt_s  = 1'b0;
    xclk_en_nxt_s = 1'b0;
    ready_nxt_s   = 1'b0;
    case (state_nxt_s)
      S_PWDN: begin
        pwdn_nxt_s    = 1'b1;
        resetb_nxt_s  = 1'b0;
        xclk_en_nxt_s = 1'b0;
        ready_nxt_s   = 1'b0;
      end
      S_RST: begin
        pwdn_nxt_s    = 1'b0;
        resetb_nxt_s  = 1'b0;
        xclk_en_nxt_s = 1'b1;
        ready_nxt_s   = 1'b0;
      end
      S_SETTLE: begin
        pwdn_nxt_s    = 1'b0;
        resetb_nxt_s  = 1'b1;
        xclk_en_nxt_s = 1'b1;
        ready_nxt_s   = 1'b0;
      end
      S_READY: begin
        // A standby request pending on entry makes S_READY a one-cycle
        // pass-through to S_STBY; ready is withheld so it never glitches.
        pwdn_nxt_s    = 1'b0;
        resetb_nxt_s  = 1'b1;
        xclk_en_nxt_s = 1'b1;
        ready_nxt_s   = ~standby_req;
      end
      S_STBY: begin
        pwdn_nxt_s    = 1'b1;
        resetb_nxt_s  = 1'b1;
        xclk_en_nxt_s = 1'b1;
        ready_nxt_s   = 1'b0;
      end
      default: begin
        pwdn_nxt_s    = 1'b1;
        resetb_nxt_s  = 1'b0;
        xclk_en_nxt_s = 1'b0;
        ready_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, counter and pin registers; async reset forces the power-down pin set.
  always_ff @(posedge mclk or negedge w_Reset_MCLKsync_n) begin
    if (!w_Reset_MCLKsync_n) begin
      state_r     <= S_PWDN;
      cnt_r       <= CNT_ZERO;
      pwdn_r      <= 1'b1;
      resetb_r    <= 1'b0;
      xclk_en_r   <= 1'b0;
      ready_r     <= 1'b0;
      seq_state_r <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pwdn_r      <= pwdn_nxt_s;
      resetb_r    <= resetb_nxt_s;
      xclk_en_r   <= xclk_en_nxt_s;
      ready_r     <= ready_nxt_s;
      seq_state_r <= state_nxt_s;
    end
  end

  assign cam_pwdn    = pwdn_r;
  assign cam_resetb  = resetb_r;
  assign cam_xclk_en = xclk_en_r;
  assign cam_ready   = ready_r;
  assign seq_state   = seq_state_r;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Testbench for cam_pwr_seq: directed power-up, a table of multi-cycle
// vectors, async reset mid-operation and random stimulus against a
// countdown-based reference model.

module tb_cam_pwr_seq;

  localparam int T_PWDN   = 4;
  localparam int T_RST    = 3;
  localparam int T_SETTLE = 5;
  localparam int CNT_W    = 24;

  // {pwdn, resetb, xclk_en, ready, state[2:0]}
  localparam logic [6:0] E_PWDN   = 7'b1000_000;
  localparam logic [6:0] E_RST    = 7'b0010_001;
  localparam logic [6:0] E_SETTLE = 7'b0110_010;
  localparam logic [6:0] E_READY  = 7'b0111_011;
  localparam logic [6:0] E_RDYGAT = 7'b0110_011;
  localparam logic [6:0] E_STBY   = 7'b1110_100;

  logic       mclk;
  logic       w_Reset_MCLKsync_n;
  logic       restart;
  logic       standby_req;
  logic       cam_pwdn;
  logic       cam_resetb;
  logic       cam_xclk_en;
  logic       cam_ready;
  logic [2:0] seq_state;

  int checks;
  int errors;
  int edge_no;

  // Reference model: phase number plus cycles remaining in that phase
  int   m_ph;
  int   m_rem;
  logic m_rdy;

  typedef struct {
    string      name;
    logic       r;
    logic       sb;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  cam_pwr_seq #(
    .T_PWDN  (T_PWDN),
    .T_RST   (T_RST),
    .T_SETTLE(T_SETTLE),
    .CNT_W   (CNT_W)
  ) dut (
    .mclk              (mclk),
    .w_Reset_MCLKsync_n(w_Reset_MCLKsync_n),
    .restart           (restart),
    .standby_req       (standby_req),
    .cam_pwdn          (cam_pwdn),
    .cam_resetb        (cam_resetb),
    .cam_xclk_en       (cam_xclk_en),
    .cam_ready         (cam_ready),
    .seq_state         (seq_state)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic int dur(input int ph);
    case (ph)
      0:       return T_PWDN;
      1:       return T_RST;
      2:       return T_SETTLE;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph  = 0;
    m_rem = T_PWDN;
    m_rdy = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic sb);
    if (r) begin
      m_ph  = 0;
      m_rem = T_PWDN;
    end else if (m_ph <= 2) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_ph  = m_ph + 1;
        m_rem = dur(m_ph);
      end
    end else if (m_ph == 3) begin
      if (sb) m_ph = 4;
    end else begin
      if (!sb) begin
        m_ph  = 2;
        m_rem = T_SETTLE;
      end
    end
    m_rdy = (m_ph == 3) && !sb;
  endtask

  function automatic logic [6:0] model_exp();
    case (m_ph)
      0:       return E_PWDN;
      1:       return E_RST;
      2:       return E_SETTLE;
      3:       return m_rdy ? E_READY : E_RDYGAT;
      default: return E_STBY;
    endcase
  endfunction

  function automatic logic [6:0] dut_vec();
    return {cam_pwdn, cam_resetb, cam_xclk_en, cam_ready, seq_state};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edge_no, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edge_no, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, advance one rising edge, sample on the next falling edge
  task automatic tick(input logic r, input logic sb);
    restart     = r;
    standby_req = sb;
    @(posedge mclk);
    model_step(r, sb);
    edge_no = edge_no + 1;
    @(negedge mclk);
    chk("model", dut_vec(), model_exp());
  endtask

  task automatic add_vec(input string name, input logic r, input logic sb,
                         input int n, input logic [6:0] exp);
    vec_t v;
    v.name = name;
    v.r    = r;
    v.sb   = sb;
    v.n    = n;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Power-up from a fresh reset release with fixed datasheet edge numbers
  task automatic powerup_seq(input string tag);
    edge_no = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b0);
      if (i == 3) begin
        chk1({tag, "_pwdn_e3"}, cam_pwdn, 1'b1);
        chk1({tag, "_xclk_e3"}, cam_xclk_en, 1'b0);
      end
      if (i == 4) chk({tag, "_e4"}, dut_vec(), E_RST);
      if (i == 6) chk1({tag, "_resetb_e6"}, cam_resetb, 1'b0);
      if (i == 7) chk({tag, "_e7"}, dut_vec(), E_SETTLE);
      if (i == 11) chk1({tag, "_ready_e11"}, cam_ready, 1'b0);
      if (i == 12) chk({tag, "_e12"}, dut_vec(), E_READY);
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    edge_no            = 0;
    restart            = 1'b0;
    standby_req        = 1'b0;
    w_Reset_MCLKsync_n = 1'b0;
    model_reset();

    repeat (3) @(negedge mclk);
    chk("reset_state", dut_vec(), E_PWDN);

    w_Reset_MCLKsync_n = 1'b1;
    powerup_seq("pu");

    // Multi-cycle vectors, starting from S_READY
    add_vec("stby_enter",     1'b0, 1'b1, 1,  E_STBY);
    add_vec("stby_hold",      1'b0, 1'b1, 3,  E_STBY);
    add_vec("stby_exit",      1'b0, 1'b0, 1,  E_SETTLE);
    add_vec("wake_m4",        1'b0, 1'b0, 4,  E_SETTLE);
    add_vec("wake_m5",        1'b0, 1'b0, 1,  E_READY);
    add_vec("rst_vs_stby",    1'b1, 1'b1, 1,  E_PWDN);
    add_vec("rst_held",       1'b1, 1'b0, 5,  E_PWDN);
    add_vec("pwdn_3",         1'b0, 1'b0, 3,  E_PWDN);
    add_vec("rst_enter",      1'b0, 1'b0, 1,  E_RST);
    add_vec("rst_cnt1",       1'b0, 1'b0, 1,  E_RST);
    add_vec("restart_in_rst", 1'b1, 1'b0, 1,  E_PWDN);
    add_vec("after_rst_11",   1'b0, 1'b0, 11, E_SETTLE);
    add_vec("after_rst_12",   1'b0, 1'b0, 1,  E_READY);
    add_vec("go_pwdn",        1'b1, 1'b0, 1,  E_PWDN);
    add_vec("to_settle",      1'b0, 1'b0, 7,  E_SETTLE);
    add_vec("settle_m4",      1'b0, 1'b0, 4,  E_SETTLE);
    add_vec("rst_on_expiry",  1'b1, 1'b0, 1,  E_PWDN);
    add_vec("recover",        1'b0, 1'b0, 12, E_READY);
    add_vec("seq_restart",    1'b1, 1'b0, 1,  E_PWDN);
    add_vec("sb_early",       1'b0, 1'b1, 11, E_SETTLE);
    add_vec("sb_ready_gated", 1'b0, 1'b1, 1,  E_RDYGAT);
    add_vec("sb_enter_e13",   1'b0, 1'b1, 1,  E_STBY);
    add_vec("sb_release",     1'b0, 1'b0, 1,  E_SETTLE);
    add_vec("sb_release_5",   1'b0, 1'b0, 5,  E_READY);

    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].n; j++) begin
        tick(vecs[k].r, vecs[k].sb);
        if (vecs[k].name == "rst_on_expiry" || vecs[k].name == "sb_early")
          chk1({vecs[k].name, "_noready"}, cam_ready, 1'b0);
      end
      chk(vecs[k].name, dut_vec(), vecs[k].exp);
    end
    restart     = 1'b0;
    standby_req = 1'b0;

    // Async reset between edges while in S_READY
    #2;
    w_Reset_MCLKsync_n = 1'b0;
    #1;
    chk("async_reset", dut_vec(), E_PWDN);
    @(negedge mclk);
    chk("async_reset_hold", dut_vec(), E_PWDN);
    model_reset();
    w_Reset_MCLKsync_n = 1'b1;
    powerup_seq("re");

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      logic r;
      logic sb;
      r  = ($urandom_range(39, 0) == 0);
      sb = standby_req;
      if ($urandom_range(19, 0) == 0) sb = ~sb;
      tick(r, sb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
